// File: rtl/uart_tx_feed_arb.sv
// Multi-channel line feeder for the UART TX FIFO: latches per-channel go edges,
// grants them round-robin and streams the granted line MSB byte first over valid/ready.

module uart_tx_feed_arb #(
  parameter int PARM_LINE_BYTES = 34,
  parameter int PARM_CHANNELS   = 2,
  parameter int PARM_SKIP_NUL   = 0
) (
  input  logic                                        i_clk_20mhz,
  input  logic                                        i_rstn_20mhz,
  input  logic [PARM_CHANNELS-1:0]                    i_tx_go,
  input  logic [PARM_CHANNELS*PARM_LINE_BYTES*8-1:0]  i_dat_ascii_lines,
  output logic [7:0]                                  o_tx_data,
  output logic                                        o_tx_valid,
  input  logic                                        i_tx_ready,
  output logic                                        o_busy,
  output logic [PARM_CHANNELS-1:0]                    o_pending,
  output logic [PARM_CHANNELS-1:0]                    o_chan_done
);

  localparam int LINE_W = PARM_LINE_BYTES * 8;
  localparam int CH_W   = (PARM_CHANNELS > 1) ? $clog2(PARM_CHANNELS) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CAPT = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]               state_q, state_d;
  logic [PARM_CHANNELS-1:0] go_prev_q;
  logic [PARM_CHANNELS-1:0] pending_q, pending_d;
  logic [PARM_CHANNELS-1:0] go_rise;
  logic [CH_W-1:0]          last_grant_q, last_grant_d;
  logic [CH_W-1:0]          grant_q, grant_d;
  logic [CH_W-1:0]          rr_grant;
  logic [LINE_W-1:0]        shift_q, shift_d;
  logic [7:0]               k_q, k_d;

  logic [7:0] top_byte;
  logic       in_data;
  logic       is_nul;
  logic       advance;

  assign go_rise  = i_tx_go & ~go_prev_q;
  assign top_byte = shift_q[LINE_W-1 -: 8];
  assign in_data  = (state_q == ST_DATA);
  assign is_nul   = (PARM_SKIP_NUL != 0) && (top_byte == 8'h00);
  // A skipped NUL advances regardless of ready since it is never offered.
  assign advance  = in_data && (is_nul || i_tx_ready);

  // Round-robin search: first pending channel strictly after the last grant.
  always_comb begin : rr_search
    logic found;
    int   idx;
    found    = 1'b0;
    idx      = 0;
    rr_grant = last_grant_q;
    for (int i = 1; i <= PARM_CHANNELS; i++) begin
      idx = (int'(last_grant_q) + i) % PARM_CHANNELS;
      if (!found && pending_q[idx]) begin
        rr_grant = CH_W'(idx);
        found    = 1'b1;
      end
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; otherwise synthesis would infer a latch to hold the old value.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    shift_d      = shift_q;
    k_d          = k_q;

    // Clear the captured channel first so a same-cycle edge re-arms it.
    pending_d = pending_q;
    if (state_q == ST_CAPT) begin
      pending_d[grant_q] = 1'b0;
    end
    pending_d = pending_d | go_rise;

    case (state_q)
      ST_IDLE: begin
        if (|pending_q) begin
          grant_d = rr_grant;
          state_d = ST_CAPT;
        end
      end
      ST_CAPT: begin
        shift_d      = i_dat_ascii_lines[int'(grant_q) * LINE_W +: LINE_W];
        k_d          = 8'(PARM_LINE_BYTES);
        last_grant_d = grant_q;
        state_d      = ST_DATA;
      end
      ST_DATA: begin
        if (advance) begin
          shift_d = shift_q << 8;
          k_d     = k_q - 8'd1;
          if (k_q == 8'd1) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
    if (!i_rstn_20mhz) begin
      state_q      <= ST_IDLE;
      go_prev_q    <= '1;
      pending_q    <= '0;
      last_grant_q <= CH_W'(PARM_CHANNELS - 1);
      grant_q      <= CH_W'(PARM_CHANNELS - 1);
      // NOTE: the line shift register is a plain register bank, not a RAM,
      // so it is reset along with the rest to keep the idle outputs defined.
      shift_q      <= '0;
      k_q          <= 8'd0;
    end else begin
      state_q      <= state_d;
      go_prev_q    <= i_tx_go;
      pending_q    <= pending_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      shift_q      <= shift_d;
      k_q          <= k_d;
    end
  end

  always_comb begin
    o_chan_done = '0;
    if (state_q == ST_DONE) begin
      o_chan_done[last_grant_q] = 1'b1;
    end
  end

  assign o_tx_data  = in_data ? top_byte : 8'h00;
  assign o_tx_valid = in_data && !is_nul;
  assign o_busy     = (state_q != ST_IDLE);
  assign o_pending  = pending_q;

endmodule

// File: tb/tb_uart_tx_feed_arb.sv
// Scoreboard bench for uart_tx_feed_arb: one plain instance (3 channels) and one
// NUL-skipping instance (2 channels), directed scenarios plus randomized traffic.

module tb_uart_tx_feed_arb;

  localparam int L  = 34;
  localparam int CA = 3;
  localparam int CB = 2;

  typedef struct {
    bit         is_done;
    logic [7:0] val;
  } ev_t;

  logic clk;
  logic rstn;

  logic [CA-1:0]     go_a, pend_a, done_a;
  logic [CA*L*8-1:0] lines_a;
  logic [7:0]        data_a;
  logic              valid_a, ready_a, busy_a;

  logic [CB-1:0]     go_b, pend_b, done_b;
  logic [CB*L*8-1:0] lines_b;
  logic [7:0]        data_b;
  logic              valid_b, ready_b, busy_b;

  logic [7:0] line_a [0:CA-1][0:L-1];
  logic [7:0] line_b [0:CB-1][0:L-1];

  ev_t exp_a[$];
  ev_t exp_b[$];
  int  last_a, last_b;
  int  rmode_a, rmode_b;
  bit  mon_a_en, mon_b_en;
  bit  stall_a, stall_b;
  logic [7:0] hold_a, hold_b;

  int n_checks = 0;
  int n_errors = 0;

  uart_tx_feed_arb #(.PARM_LINE_BYTES(L), .PARM_CHANNELS(CA), .PARM_SKIP_NUL(0)) dut_a (
    .i_clk_20mhz(clk), .i_rstn_20mhz(rstn), .i_tx_go(go_a), .i_dat_ascii_lines(lines_a),
    .o_tx_data(data_a), .o_tx_valid(valid_a), .i_tx_ready(ready_a), .o_busy(busy_a),
    .o_pending(pend_a), .o_chan_done(done_a));

  uart_tx_feed_arb #(.PARM_LINE_BYTES(L), .PARM_CHANNELS(CB), .PARM_SKIP_NUL(1)) dut_b (
    .i_clk_20mhz(clk), .i_rstn_20mhz(rstn), .i_tx_go(go_b), .i_dat_ascii_lines(lines_b),
    .o_tx_data(data_b), .o_tx_valid(valid_b), .i_tx_ready(ready_b), .o_busy(busy_b),
    .o_pending(pend_b), .o_chan_done(done_b));

  initial begin
    clk = 1'b0;
    forever #25 clk = ~clk;
  end

  initial begin
    #(50 * 90000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string msg);
    n_checks++;
    n_errors++;
    $display("FAIL %s: %s", name, msg);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ready generators: 0 = always ready, 1 = alternating, 2 = random ~75%.
  initial begin
    ready_a = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode_a)
        1:       ready_a = ~ready_a;
        2:       ready_a = ($urandom_range(0, 3) != 0);
        default: ready_a = 1'b1;
      endcase
    end
  end

  initial begin
    ready_b = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode_b)
        1:       ready_b = ~ready_b;
        2:       ready_b = ($urandom_range(0, 3) != 0);
        default: ready_b = 1'b1;
      endcase
    end
  end

  task automatic pack_lines();
    for (int c = 0; c < CA; c++)
      for (int j = 0; j < L; j++)
        lines_a[c*L*8 + (L-1-j)*8 +: 8] = line_a[c][j];
    for (int c = 0; c < CB; c++)
      for (int j = 0; j < L; j++)
        lines_b[c*L*8 + (L-1-j)*8 +: 8] = line_b[c][j];
  endtask

  // Reference model: a granted line yields its bytes in order, then a done pulse.
  task automatic push_line_a(input int c);
    ev_t e;
    for (int j = 0; j < L; j++) begin
      e.is_done = 1'b0;
      e.val     = line_a[c][j];
      exp_a.push_back(e);
    end
    e.is_done = 1'b1;
    e.val     = 8'(1 << c);
    exp_a.push_back(e);
    last_a = c;
  endtask

  task automatic push_line_b(input int c);
    ev_t e;
    for (int j = 0; j < L; j++) begin
      if (line_b[c][j] != 8'h00) begin
        e.is_done = 1'b0;
        e.val     = line_b[c][j];
        exp_b.push_back(e);
      end
    end
    e.is_done = 1'b1;
    e.val     = 8'(1 << c);
    exp_b.push_back(e);
    last_b = c;
  endtask

  task automatic pulse_a(input logic [CA-1:0] m);
    go_a = m;
    tick();
    go_a = '0;
  endtask

  task automatic pulse_b(input logic [CB-1:0] m);
    go_b = m;
    tick();
    go_b = '0;
  endtask

  task automatic wait_idle_a(input int budget, input string name);
    int n = 0;
    @(negedge clk);
    while (!(busy_a == 1'b0 && pend_a == '0 && exp_a.size() == 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) fail(name, $sformatf("no idle after %0d cycles, %0d events left", budget, exp_a.size()));
    tick();
  endtask

  task automatic wait_idle_b(input int budget, input string name);
    int n = 0;
    @(negedge clk);
    while (!(busy_b == 1'b0 && pend_b == '0 && exp_b.size() == 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) fail(name, $sformatf("no idle after %0d cycles, %0d events left", budget, exp_b.size()));
    tick();
  endtask

  // Monitors: pop the scoreboard on every handshake and every done pulse.
  always @(negedge clk) begin : mon_a
    ev_t e;
    if (!rstn || !mon_a_en) begin
      stall_a = 1'b0;
    end else begin
      if (stall_a) begin
        check("a_stall_valid", valid_a, 1);
        check("a_stall_data", data_a, hold_a);
      end
      if (!valid_a) check("a_idle_data", data_a, 0);
      if (valid_a && ready_a) begin
        if (exp_a.size() == 0) fail("a_byte", $sformatf("unexpected byte 0x%0h", data_a));
        else begin
          e = exp_a.pop_front();
          if (e.is_done) fail("a_byte", $sformatf("got byte 0x%0h, expected done 0x%0h", data_a, e.val));
          else check("a_byte", data_a, e.val);
        end
      end
      if (done_a != '0) begin
        if (exp_a.size() == 0) fail("a_done", $sformatf("unexpected done 0x%0h", done_a));
        else begin
          e = exp_a.pop_front();
          if (!e.is_done) fail("a_done", $sformatf("got done 0x%0h, expected byte 0x%0h", done_a, e.val));
          else check("a_done", done_a, e.val);
        end
      end
      stall_a = valid_a && !ready_a;
      hold_a  = data_a;
    end
  end

  always @(negedge clk) begin : mon_b
    ev_t e;
    if (!rstn || !mon_b_en) begin
      stall_b = 1'b0;
    end else begin
      if (stall_b) begin
        check("b_stall_valid", valid_b, 1);
        check("b_stall_data", data_b, hold_b);
      end
      if (valid_b) check("b_no_nul_offered", (data_b != 8'h00), 1);
      if (valid_b && ready_b) begin
        if (exp_b.size() == 0) fail("b_byte", $sformatf("unexpected byte 0x%0h", data_b));
        else begin
          e = exp_b.pop_front();
          if (e.is_done) fail("b_byte", $sformatf("got byte 0x%0h, expected done 0x%0h", data_b, e.val));
          else check("b_byte", data_b, e.val);
        end
      end
      if (done_b != '0) begin
        if (exp_b.size() == 0) fail("b_done", $sformatf("unexpected done 0x%0h", done_b));
        else begin
          e = exp_b.pop_front();
          if (!e.is_done) fail("b_done", $sformatf("got done 0x%0h, expected byte 0x%0h", done_b, e.val));
          else check("b_done", done_b, e.val);
        end
      end
      stall_b = valid_b && !ready_b;
      hold_b  = data_b;
    end
  end

  initial begin
    int cnt, hs, guard, start;
    bit first_ready;
    logic [CA-1:0] ma;
    logic [CB-1:0] mb;

    rstn = 1'b0; go_a = '0; go_b = '0;
    rmode_a = 0; rmode_b = 0; mon_a_en = 1'b1; mon_b_en = 1'b1;
    last_a = CA - 1; last_b = CB - 1;
    for (int c = 0; c < CA; c++) for (int j = 0; j < L; j++) line_a[c][j] = 8'($urandom);
    for (int c = 0; c < CB; c++) for (int j = 0; j < L; j++) line_b[c][j] = 8'($urandom_range(1, 255));
    for (int j = 0; j < 32; j++) line_a[0][j] = 8'(8'h41 + j);
    line_a[0][32] = 8'h0D;
    line_a[0][33] = 8'h0A;
    pack_lines();

    repeat (3) @(negedge clk);
    check("rst_valid_a", valid_a, 0);
    check("rst_data_a", data_a, 0);
    check("rst_busy_a", busy_a, 0);
    check("rst_pending_a", pend_a, 0);
    check("rst_done_a", done_a, 0);
    check("rst_valid_b", valid_b, 0);
    check("rst_busy_b", busy_b, 0);
    check("rst_pending_b", pend_b, 0);
    @(posedge clk);
    #5 rstn = 1'b1;
    tick();

    // Single line, ready held high: latency, run length, done and busy timing.
    push_line_a(0);
    pulse_a(3'b001);
    @(negedge clk);
    check("t1_pending", pend_a, 3'b001);
    check("t1_valid_t0", valid_a, 0);
    @(negedge clk);
    check("t1_busy_capt", busy_a, 1);
    check("t1_valid_t1", valid_a, 0);
    @(negedge clk);
    check("t1_valid_t2", valid_a, 1);
    cnt = 1; guard = 0;
    do begin
      @(negedge clk);
      guard++;
      if (valid_a) cnt++;
    end while (valid_a && guard < 200);
    check("t1_valid_run", cnt, 34);
    check("t1_done_timing", done_a, 3'b001);
    check("t1_busy_in_done", busy_a, 1);
    @(negedge clk);
    check("t1_busy_low", busy_a, 0);
    wait_idle_a(200, "t1_idle");

    // Backpressure: alternating ready, 34 handshakes, one or two cycles per byte.
    rmode_a = 1;
    push_line_a(0);
    pulse_a(3'b001);
    guard = 0;
    while (!valid_a && guard < 20) begin @(negedge clk); guard++; end
    if (!valid_a) fail("t2_start", "no valid within 20 cycles");
    first_ready = ready_a;
    cnt = 1;
    do begin
      @(negedge clk);
      guard++;
      if (valid_a) cnt++;
    end while (valid_a && guard < 300);
    check("t2_data_cycles", cnt, first_ready ? 67 : 68);
    wait_idle_a(300, "t2_idle");
    rmode_a = 0;
    tick();

    // Arbitration: ch1, then ch0+ch1 together, then ch0 again during ch0's line.
    for (int c = 1; c < CA; c++) for (int j = 0; j < L; j++) line_a[c][j] = 8'($urandom);
    pack_lines();
    push_line_a(1);
    pulse_a(3'b010);
    guard = 0;
    while (!valid_a && guard < 20) begin @(negedge clk); guard++; end
    push_line_a(0);
    push_line_a(1);
    pulse_a(3'b011);
    @(negedge clk);
    check("t3_pending_both", pend_a, 3'b011);
    guard = 0;
    while (!(pend_a[0] == 1'b0 && valid_a) && guard < 500) begin @(negedge clk); guard++; end
    if (guard >= 500) fail("t3_ch0_start", "channel 0 line never started");
    tick();
    push_line_a(0);
    pulse_a(3'b001);
    wait_idle_a(1000, "t3_idle");

    // NUL skipping: zeros at positions 5 and 34, then an all-zero line.
    for (int j = 0; j < L; j++) line_b[0][j] = 8'(8'h41 + j);
    line_b[0][4]  = 8'h00;
    line_b[0][33] = 8'h00;
    pack_lines();
    push_line_b(0);
    pulse_b(2'b01);
    hs = 0; guard = 0;
    while (!busy_b && guard < 20) begin @(negedge clk); guard++; end
    while (busy_b && guard < 400) begin
      if (valid_b && ready_b) hs++;
      @(negedge clk);
      guard++;
    end
    check("t4_skip_handshakes", hs, 32);
    wait_idle_b(200, "t4_idle");
    for (int j = 0; j < L; j++) line_b[0][j] = 8'h00;
    pack_lines();
    push_line_b(0);
    pulse_b(2'b01);
    hs = 0; cnt = 0; guard = 0;
    while (!busy_b && guard < 20) begin @(negedge clk); guard++; end
    while (busy_b && guard < 400) begin
      if (valid_b && ready_b) hs++;
      cnt++;
      @(negedge clk);
      guard++;
    end
    check("t4_zero_handshakes", hs, 0);
    check("t4_zero_busy_cycles", cnt, 36);
    wait_idle_b(200, "t4_zero_idle");

    // Reset mid-line with go[0] held high.
    mon_a_en = 1'b0;
    go_a = 3'b001;
    hs = 0; guard = 0;
    while (hs < 10 && guard < 300) begin
      @(negedge clk);
      guard++;
      if (valid_a && ready_a) hs++;
    end
    if (hs < 10) fail("t5_handshakes", $sformatf("only %0d handshakes before reset", hs));
    @(posedge clk);
    #5 rstn = 1'b0;
    #1;
    check("t5_async_valid", valid_a, 0);
    check("t5_async_data", data_a, 0);
    check("t5_async_busy", busy_a, 0);
    check("t5_async_pending", pend_a, 0);
    check("t5_async_done", done_a, 0);
    last_a = CA - 1;
    last_b = CB - 1;
    repeat (2) @(negedge clk);
    check("t5_no_done", done_a, 0);
    @(posedge clk);
    #5 rstn = 1'b1;
    mon_a_en = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("t5_no_refire_busy", busy_a, 0);
    end
    check("t5_no_refire_pending", pend_a, 0);
    tick();
    go_a = '0;
    tick();
    push_line_a(0);
    pulse_a(3'b001);
    wait_idle_a(200, "t5_idle");

    // Randomized traffic on both instances with random backpressure.
    rmode_a = 2;
    for (int it = 0; it < 40; it++) begin
      for (int c = 0; c < CA; c++) for (int j = 0; j < L; j++) line_a[c][j] = 8'($urandom);
      pack_lines();
      ma = CA'($urandom_range(1, (1 << CA) - 1));
      start = last_a;
      for (int i = 1; i <= CA; i++)
        if (ma[(start + i) % CA]) push_line_a((start + i) % CA);
      pulse_a(ma);
      wait_idle_a(2000, "rand_a_idle");
    end
    rmode_b = 2;
    for (int it = 0; it < 30; it++) begin
      for (int c = 0; c < CB; c++)
        for (int j = 0; j < L; j++)
          line_b[c][j] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      pack_lines();
      mb = CB'($urandom_range(1, (1 << CB) - 1));
      start = last_b;
      for (int i = 1; i <= CB; i++)
        if (mb[(start + i) % CB]) push_line_b((start + i) % CB);
      pulse_b(mb);
      wait_idle_b(2000, "rand_b_idle");
    end

    check("final_queue_a", exp_a.size(), 0);
    check("final_queue_b", exp_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
